// File: rtl/banked_mem_ctrl.sv
// ez8 data-memory controller: special registers, FSR/INDF indirect access with post-increment,
// an IO window and banked GP RAM. Reads are registered and presented one cycle later.
module banked_mem_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int NUM_BANKS = 4,
  parameter int NUM_FSR   = 4,
  parameter int IO_AW     = 3,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pause,
  input  logic                    zin,
  input  logic                    z_write,
  input  logic                    cin,
  input  logic                    c_write,
  input  logic                    giein,
  input  logic                    gie_write,
  output logic                    cout,
  input  logic [ADDR_W-1:0]       writeaddr,
  input  logic [DATA_W-1:0]       writedata,
  input  logic                    write_en,
  input  logic [ADDR_W-1:0]       readaddr,
  output logic [DATA_W-1:0]       readdata,
  output logic [BANK_W+IO_AW-1:0] io_readaddr,
  input  logic [DATA_W-1:0]       io_readdata,
  output logic [BANK_W+IO_AW-1:0] io_writeaddr,
  output logic [DATA_W-1:0]       io_writedata,
  output logic                    io_write_en,
  input  logic [DATA_W-1:0]       irq_in,
  output logic                    irq,
  input  logic                    accum_write,
  output logic [DATA_W-1:0]       accum_out
);
  localparam int FSR_IW   = (NUM_FSR > 1) ? $clog2(NUM_FSR) : 1;
  localparam int GP_DEPTH = (1 << ADDR_W) - 16;
  localparam logic [ADDR_W-1:0] A_STATUS    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_INTCON    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_INTSTATUS = ADDR_W'(3);

  function automatic logic is_fsr(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(4)) && (a < ADDR_W'(4 + NUM_FSR));
  endfunction

  function automatic logic is_io(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(8)) && (a < ADDR_W'(8 + (1 << IO_AW)));
  endfunction

  function automatic logic is_gp(input logic [ADDR_W-1:0] a);
    return a >= ADDR_W'(16);
  endfunction

  function automatic logic [FSR_IW-1:0] fsr_index(input logic [ADDR_W-1:0] a);
    return FSR_IW'(a[1:0] & 2'(NUM_FSR - 1));
  endfunction

  logic [DATA_W-1:0] status_q, status_d, intcon_q, intcon_d;
  logic [DATA_W-1:0] intstatus_q, intstatus_d, accum_q, accum_d;
  logic [ADDR_W-1:0] fsr_q [NUM_FSR];
  logic [ADDR_W-1:0] fsr_d [NUM_FSR];
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [BANK_W-1:0] rbank_q, rbank_d;
  logic              fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic [DATA_W-1:0] mem [NUM_BANKS][GP_DEPTH];
  logic [DATA_W-1:0] ram_rdata;

  logic [FSR_IW-1:0] fsr_sel;
  logic [ADDR_W-1:0] indf_ptr, eff_raddr, eff_waddr, gp_ridx, gp_widx;
  logic [BANK_W-1:0] bank;
  logic              wr, indf_acc;

  // Address resolution; a STATUS write this cycle already steers the bank.
  always_comb begin
    fsr_sel   = FSR_IW'(status_q[3:2] & 2'(NUM_FSR - 1));
    indf_ptr  = fsr_q[fsr_sel];
    eff_raddr = (readaddr == '0) ? indf_ptr : readaddr;
    eff_waddr = (writeaddr == '0) ? indf_ptr : writeaddr;
    wr        = write_en && !pause && (eff_waddr != '0);
    indf_acc  = (readaddr == '0) || (write_en && (writeaddr == '0));
    bank      = BANK_W'(((wr && eff_waddr == A_STATUS) ? writedata[6:5] : status_q[6:5])
                        & 2'(NUM_BANKS - 1));
    gp_ridx   = is_gp(eff_raddr) ? eff_raddr - ADDR_W'(16) : '0;
    gp_widx   = is_gp(eff_waddr) ? eff_waddr - ADDR_W'(16) : '0;
  end

  always_comb begin
    status_d    = status_q;
    intcon_d    = intcon_q;
    accum_d     = accum_q;
    fsr_d       = fsr_q;
    raddr_d     = raddr_q;
    rbank_d     = rbank_q;
    fwd_d       = fwd_q;
    fwd_data_d  = fwd_data_q;
    // Interrupt latching keeps running through a stall; hardware set beats a software clear.
    intstatus_d = ((wr && eff_waddr == A_INTSTATUS) ? writedata : intstatus_q) | irq_in;
    if (!pause) begin
      if (wr && eff_waddr == A_STATUS) begin
        status_d = writedata;
      end else begin
        if (z_write)   status_d[0] = zin;
        if (c_write)   status_d[1] = cin;
        if (gie_write) status_d[7] = giein;
      end
      if (wr && eff_waddr == A_INTCON) intcon_d = writedata;
      if (accum_write) accum_d = writedata;
      if (status_q[4] && indf_acc) fsr_d[fsr_sel] = indf_ptr + ADDR_W'(1);
      if (wr && is_fsr(eff_waddr)) fsr_d[fsr_index(eff_waddr)] = writedata[ADDR_W-1:0];
      raddr_d    = eff_raddr;
      rbank_d    = bank;
      fwd_d      = wr && (eff_waddr == eff_raddr);
      fwd_data_d = writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q    <= '0;
      intcon_q    <= '0;
      intstatus_q <= '0;
      accum_q     <= '0;
      for (int i = 0; i < NUM_FSR; i++) fsr_q[i] <= '0;
      raddr_q     <= '0;
      rbank_q     <= '0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      status_q    <= status_d;
      intcon_q    <= intcon_d;
      intstatus_q <= intstatus_d;
      accum_q     <= accum_d;
      fsr_q       <= fsr_d;
      raddr_q     <= raddr_d;
      rbank_q     <= rbank_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!pause) begin
      if (!reset && wr && is_gp(eff_waddr)) mem[bank][gp_widx] <= writedata;
      ram_rdata <= mem[bank][gp_ridx];
    end
  end

  always_comb begin
    readdata = '0;
    if (fwd_q)                          readdata = fwd_data_q;
    else if (raddr_q == '0)             readdata = '0;
    else if (raddr_q == A_STATUS)       readdata = status_q;
    else if (raddr_q == A_INTCON)       readdata = intcon_q;
    else if (raddr_q == A_INTSTATUS)    readdata = intstatus_q;
    else if (is_fsr(raddr_q))           readdata = DATA_W'(fsr_q[fsr_index(raddr_q)]);
    else if (is_io(raddr_q))            readdata = io_readdata;
    else if (is_gp(raddr_q))            readdata = ram_rdata;
  end

  assign io_readaddr  = {rbank_q, raddr_q[IO_AW-1:0]};
  assign io_writeaddr = {bank, eff_waddr[IO_AW-1:0]};
  assign io_writedata = writedata;
  assign io_write_en  = write_en && !pause && is_io(eff_waddr);
  assign irq          = status_q[7] && |(intcon_q & intstatus_q);
  assign cout         = status_q[1];
  assign accum_out    = accum_q;
endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Bench for banked_mem_ctrl: a transaction-level model predicts each cycle's outputs into a
// scoreboard queue; a negedge monitor pops and compares them against the DUT.
module tb_banked_mem_ctrl;
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, pause, zin, z_write, cin, c_write, giein, gie_write, cout;
  logic [7:0] writeaddr, writedata, readaddr, readdata, io_readdata, io_writedata;
  logic [7:0] irq_in, accum_out;
  logic [4:0] io_readaddr, io_writeaddr;
  logic       write_en, io_write_en, irq, accum_write;

  function automatic logic [7:0] io_fn(input logic [4:0] a);
    return {3'b011, a} ^ 8'h5A;
  endfunction

  assign io_readdata = io_fn(io_readaddr);

  banked_mem_ctrl dut (
    .clk(clk), .reset(reset), .pause(pause),
    .zin(zin), .z_write(z_write), .cin(cin), .c_write(c_write),
    .giein(giein), .gie_write(gie_write), .cout(cout),
    .writeaddr(writeaddr), .writedata(writedata), .write_en(write_en),
    .readaddr(readaddr), .readdata(readdata),
    .io_readaddr(io_readaddr), .io_readdata(io_readdata),
    .io_writeaddr(io_writeaddr), .io_writedata(io_writedata), .io_write_en(io_write_en),
    .irq_in(irq_in), .irq(irq), .accum_write(accum_write), .accum_out(accum_out)
  );

  typedef struct {
    logic rst, pause, we, zi, zw, ci, cw, gi, gw, aw;
    logic [7:0] wa, wd, ra, irq;
  } stim_t;

  // kind 0: post-edge outputs, 1: same-cycle IO write port, 2: constant readdata, 3: constant irq
  typedef struct {
    int due; int kind; int tag;
    logic rd_ok; logic [7:0] rd; logic irq; logic cout; logic [7:0] acc;
    logic [4:0] ioa; logic iowe;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state of the memory map
  logic [7:0] status_m, intcon_m, intstat_m, accum_m;
  logic [7:0] fsr_m [4];
  logic [7:0] mem_m [4][256];
  bit         mem_v [4][256];
  // What the most recent (unstalled) read is showing
  bit         rd_fixed, rd_ok_m;
  logic [7:0] rd_val, rd_addr;
  logic [1:0] rd_bank;

  function automatic logic [7:0] rd_eval();
    if (rd_fixed) return rd_val;
    case (rd_addr)
      8'h01:   return status_m;
      8'h02:   return intcon_m;
      8'h03:   return intstat_m;
      8'h04, 8'h05, 8'h06, 8'h07: return fsr_m[rd_addr[1:0]];
      default: return io_fn({rd_bank, rd_addr[2:0]});
    endcase
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s#%0d: got 0x%0h, expected 0x%0h (cycle %0d)", nm, tag, act, exp, cyc);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.pause = 0; s.we = 0; s.zi = 0; s.zw = 0; s.ci = 0; s.cw = 0;
    s.gi = 0; s.gw = 0; s.aw = 0; s.wa = 8'h01; s.wd = 8'h00; s.ra = 8'h01; s.irq = 8'h00;
    return s;
  endfunction

  task automatic step(input stim_t s);
    logic [1:0] sel, bank;
    logic [7:0] ew, er, ist_next, old_status;
    bit         do_w;
    exp_t       e;
    @(posedge clk); #1;
    reset = s.rst; pause = s.pause; write_en = s.we; writeaddr = s.wa; writedata = s.wd;
    readaddr = s.ra; irq_in = s.irq; zin = s.zi; z_write = s.zw; cin = s.ci; c_write = s.cw;
    giein = s.gi; gie_write = s.gw; accum_write = s.aw;

    old_status = status_m;
    sel  = old_status[3:2];
    ew   = (s.wa == 8'h00) ? fsr_m[sel] : s.wa;
    er   = (s.ra == 8'h00) ? fsr_m[sel] : s.ra;
    do_w = s.we && !s.pause && (ew != 8'h00);
    bank = (do_w && ew == 8'h01) ? s.wd[6:5] : old_status[6:5];

    e.due = cyc; e.kind = 1; e.tag = 0; e.rd = s.wd;
    e.iowe = s.we && !s.pause && (ew >= 8'h08) && (ew < 8'h10);
    e.ioa  = {bank, ew[2:0]};
    sb.push_back(e);

    if (s.rst) begin
      status_m = 0; intcon_m = 0; intstat_m = 0; accum_m = 0;
      for (int i = 0; i < 4; i++) fsr_m[i] = 0;
      rd_fixed = 1; rd_ok_m = 1; rd_val = 0; rd_addr = 0; rd_bank = 0;
    end else begin
      ist_next = ((do_w && ew == 8'h03) ? s.wd : intstat_m) | s.irq;
      if (!s.pause) begin
        rd_addr = er; rd_bank = bank; rd_ok_m = 1;
        if (do_w && ew == er) begin rd_fixed = 1; rd_val = s.wd; end
        else if (er == 8'h00) begin rd_fixed = 1; rd_val = 8'h00; end
        else if (er < 8'h10) rd_fixed = 0;
        else begin rd_fixed = 1; rd_ok_m = mem_v[bank][er]; rd_val = mem_m[bank][er]; end
        if (old_status[4] && (s.ra == 8'h00 || (s.we && s.wa == 8'h00)))
          fsr_m[sel] = fsr_m[sel] + 8'd1;
        if (do_w && ew >= 8'h04 && ew < 8'h08) fsr_m[ew[1:0]] = s.wd;
        if (do_w && ew == 8'h01) status_m = s.wd;
        else begin
          if (s.zw) status_m[0] = s.zi;
          if (s.cw) status_m[1] = s.ci;
          if (s.gw) status_m[7] = s.gi;
        end
        if (do_w && ew == 8'h02) intcon_m = s.wd;
        if (s.aw) accum_m = s.wd;
        if (do_w && ew >= 8'h10) begin mem_m[bank][ew] = s.wd; mem_v[bank][ew] = 1; end
      end
      intstat_m = ist_next;
    end

    e.due = cyc + 1; e.kind = 0; e.rd_ok = rd_ok_m; e.rd = rd_eval();
    e.irq = status_m[7] & (|(intcon_m & intstat_m)); e.cout = status_m[1];
    e.acc = accum_m; e.ioa = {rd_bank, rd_addr[2:0]};
    sb.push_back(e);
  endtask

  task automatic expect_const(input int kind, input logic [7:0] v, input int tag);
    exp_t e;
    e.due = cyc + 1; e.kind = kind; e.tag = tag; e.rd = v; e.irq = v[0];
    sb.push_back(e);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] r);
    stim_t s;
    s = idle(); s.we = 1; s.wa = a; s.wd = d; s.ra = r;
    step(s);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] v, input int tag);
    stim_t s;
    s = idle(); s.ra = a;
    step(s);
    expect_const(2, v, tag);
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'($urandom_range(1, 7));
      2:       return 8'($urandom_range(8, 15));
      3:       return 8'(8'h10 + $urandom_range(0, 3));
      4:       return 8'(8'hFC + $urandom_range(0, 3));
      default: return 8'(8'h40 + $urandom_range(0, 3));
    endcase
  endfunction

  exp_t m;
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      m = sb.pop_front();
      if (m.due != cyc) chk("entry_due", m.tag, 32'(cyc), 32'(m.due));
      else case (m.kind)
        0: begin
          if (m.rd_ok) chk("readdata", 0, 32'(readdata), 32'(m.rd));
          chk("irq", 0, 32'(irq), 32'(m.irq));
          chk("cout", 0, 32'(cout), 32'(m.cout));
          chk("accum_out", 0, 32'(accum_out), 32'(m.acc));
          chk("io_readaddr", 0, 32'(io_readaddr), 32'(m.ioa));
        end
        1: begin
          chk("io_write_en", 0, 32'(io_write_en), 32'(m.iowe));
          chk("io_writedata", 0, 32'(io_writedata), 32'(m.rd));
          if (m.iowe) chk("io_writeaddr", 0, 32'(io_writeaddr), 32'(m.ioa));
        end
        2: chk("const_readdata", m.tag, 32'(readdata), 32'(m.rd));
        default: chk("const_irq", m.tag, 32'(irq), 32'(m.irq));
      endcase
    end
  end

  initial begin
    stim_t s;
    reset = 1; pause = 0; write_en = 0; writeaddr = 8'h01; writedata = 0; readaddr = 8'h01;
    irq_in = 0; zin = 0; z_write = 0; cin = 0; c_write = 0; giein = 0; gie_write = 0;
    accum_write = 0;

    s = idle(); s.rst = 1;
    step(s); step(s);
    expect_const(2, 8'h00, 1); expect_const(3, 8'h00, 1);

    // Banking: same GP address in bank 0 and bank 1
    wr(8'h20, 8'h5A, 8'h01);
    rd(8'h20, 8'h5A, 2);
    wr(8'h01, 8'h20, 8'h01);
    wr(8'h20, 8'hA5, 8'h01);
    rd(8'h20, 8'hA5, 3);
    wr(8'h01, 8'h00, 8'h01);
    rd(8'h20, 8'h5A, 4);

    // INDF burst with post-increment
    wr(8'h01, 8'h10, 8'h01);
    wr(8'h04, 8'h30, 8'h01);
    wr(8'h00, 8'h11, 8'h01);
    wr(8'h00, 8'h22, 8'h01);
    rd(8'h04, 8'h32, 5);
    wr(8'h01, 8'h00, 8'h01);
    rd(8'h30, 8'h11, 6);
    rd(8'h31, 8'h22, 7);

    // STATUS write beats Z strobe, then a lone strobe sets Z
    s = idle(); s.we = 1; s.wa = 8'h01; s.wd = 8'h00; s.zw = 1; s.zi = 1; s.ra = 8'h02;
    step(s);
    rd(8'h01, 8'h00, 8);
    s = idle(); s.zw = 1; s.zi = 1; s.ra = 8'h01;
    step(s);
    expect_const(2, 8'h01, 9);

    // Interrupt latching, irq, and hardware set winning over a clear
    wr(8'h02, 8'h01, 8'h02);
    s = idle(); s.gw = 1; s.gi = 1;
    step(s);
    s = idle(); s.irq = 8'h01; s.ra = 8'h03;
    step(s);
    expect_const(2, 8'h01, 10); expect_const(3, 8'h01, 11);
    s = idle(); s.we = 1; s.wa = 8'h03; s.wd = 8'h00; s.irq = 8'h01;
    step(s);
    rd(8'h03, 8'h01, 12); expect_const(3, 8'h01, 13);
    wr(8'h03, 8'h00, 8'h01);
    rd(8'h03, 8'h00, 14); expect_const(3, 8'h00, 15);

    // Same-cycle write/read forwarding, then a stall
    wr(8'h40, 8'h77, 8'h40);
    expect_const(2, 8'h77, 16);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.pause = 1; s.we = 1; s.wa = (i == 1) ? 8'h09 : 8'h40; s.wd = 8'h99;
      s.ra = 8'h20;
      step(s);
      expect_const(2, 8'h77, 17 + i);
    end
    rd(8'h40, 8'h77, 20);

    // Reset in the middle of an INDF auto-increment burst
    wr(8'h01, 8'h10, 8'h01);
    wr(8'h04, 8'h50, 8'h01);
    wr(8'h00, 8'hC1, 8'h01);
    wr(8'h00, 8'hC2, 8'h01);
    s = idle(); s.rst = 1; s.we = 1; s.wa = 8'h00; s.wd = 8'hC3; s.ra = 8'h00;
    step(s);
    expect_const(2, 8'h00, 21);
    rd(8'h04, 8'h00, 22);
    rd(8'h01, 8'h00, 23);
    rd(8'h50, 8'hC1, 24);

    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 199) == 0);
      s.pause = ($urandom_range(0, 9) == 0);
      s.we    = 1'($urandom_range(0, 1));
      s.wa    = rand_addr();
      s.ra    = rand_addr();
      s.wd    = 8'($urandom);
      s.irq   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      s.zw = 1'($urandom_range(0, 1)); s.zi = 1'($urandom_range(0, 1));
      s.cw = 1'($urandom_range(0, 1)); s.ci = 1'($urandom_range(0, 1));
      s.gw = ($urandom_range(0, 3) == 0); s.gi = 1'($urandom_range(0, 1));
      s.aw = 1'($urandom_range(0, 1));
      step(s);
    end

    s = idle();
    step(s);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard_drain", 0, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
